// File: rtl/mips_cpu_lsu.sv
// mips_cpu_lsu -- load/store unit between the multicycle MIPS32 core and an
// Avalon-MM master port. Instruction fetch shares the same request port.
//
// The core issues one request at a time (req_valid && req_ready) and waits for
// a one-cycle resp_valid pulse. Accepted requests go IDLE -> BUS -> RESP -> IDLE,
// or IDLE -> RESP directly when the request is rejected (illegal op, misaligned).
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/req_ready core request handshake (ready only while idle)
//   req_op              0 LW,1 LH,2 LHU,3 LB,4 LBU,5 LWL,6 LWR,7 SW,8 SH,9 SB,10 FETCH
//   req_addr            byte address
//   req_wdata           store data (rt)
//   req_rt_old          current rt, merge source for LWL/LWR
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load/fetch result, 0 for stores and errors
//   resp_err            misaligned, illegal op or bus timeout
//   address/read/write/waitrequest/writedata/byteenable/readdata  Avalon-MM master
//
// Parameters
//   TIMEOUT_CYCLES  consecutive waitrequest cycles before the transfer is aborted
//                   (0 disables the timeout)
//   ALIGN_CHECK     1: misaligned word/half accesses are errors; 0: the offending
//                   low address bits are treated as zero
module mips_cpu_lsu #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter bit ALIGN_CHECK    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [3:0] OP_LW    = 4'd0;
  localparam logic [3:0] OP_LH    = 4'd1;
  localparam logic [3:0] OP_LHU   = 4'd2;
  localparam logic [3:0] OP_LB    = 4'd3;
  localparam logic [3:0] OP_LBU   = 4'd4;
  localparam logic [3:0] OP_LWL   = 4'd5;
  localparam logic [3:0] OP_LWR   = 4'd6;
  localparam logic [3:0] OP_SW    = 4'd7;
  localparam logic [3:0] OP_SH    = 4'd8;
  localparam logic [3:0] OP_SB    = 4'd9;
  localparam logic [3:0] OP_FETCH = 4'd10;

  // Wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int              CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [3:0]    op_r, op_s;
  logic [1:0]    lane_r, lane_s;
  logic [31:0]   rt_r, rt_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          req_ready_r, req_ready_s;
  logic          resp_valid_r, resp_valid_s;
  logic          resp_err_r, resp_err_s;
  logic [31:0]   resp_rdata_r, resp_rdata_s;
  logic [31:0]   address_r, address_s;
  logic          read_r, read_s;
  logic          write_r, write_s;
  logic [31:0]   writedata_r, writedata_s;
  logic [3:0]    byteenable_r, byteenable_s;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] n);
    logic r;
    case (op)
      OP_LW, OP_SW, OP_FETCH: r = (n != 2'b00);
      OP_LH, OP_LHU, OP_SH:   r = n[0];
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Lane actually used for the access; with alignment checking off the
  // offending low bits are cleared instead of raising an error.
  function automatic logic [1:0] eff_lane(input logic [3:0] op, input logic [1:0] n);
    logic [1:0] r;
    if (!ALIGN_CHECK) begin
      case (op)
        OP_LW, OP_SW, OP_FETCH: r = 2'b00;
        OP_LH, OP_LHU, OP_SH:   r = {n[1], 1'b0};
        default:                r = n;
      endcase
    end else begin
      r = n;
    end
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] n);
    logic [3:0] r;
    case (op)
      OP_SB:   r = 4'b0001 << n;
      OP_SH:   r = n[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      OP_SB:   r = {4{d[7:0]}};
      OP_SH:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] n,
                                              input logic [31:0] m, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (n)
      2'd0:    b = m[7:0];
      2'd1:    b = m[15:8];
      2'd2:    b = m[23:16];
      2'd3:    b = m[31:24];
      default: b = 8'h00;
    endcase
    h = n[1] ? m[31:16] : m[15:0];
    case (op)
      OP_LB:  r = {{24{b[7]}}, b};
      OP_LBU: r = {24'h000000, b};
      OP_LH:  r = {{16{h[15]}}, h};
      OP_LHU: r = {16'h0000, h};
      OP_LWL: begin
        case (n)
          2'd0:    r = {m[7:0], rt[23:0]};
          2'd1:    r = {m[15:0], rt[15:0]};
          2'd2:    r = {m[23:0], rt[7:0]};
          default: r = m;
        endcase
      end
      OP_LWR: begin
        case (n)
          2'd1:    r = {rt[31:24], m[31:8]};
          2'd2:    r = {rt[31:16], m[31:16]};
          2'd3:    r = {rt[31:8], m[31:24]};
          default: r = m;
        endcase
      end
      default: r = m;
    endcase
    return r;
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s      = state_r;
    op_s         = op_r;
    lane_s       = lane_r;
    rt_s         = rt_r;
    cnt_s        = cnt_r;
    resp_valid_s = 1'b0;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'h0000_0000;
    address_s    = address_r;
    read_s       = read_r;
    write_s      = write_r;
    writedata_s  = writedata_r;
    byteenable_s = byteenable_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          op_s   = req_op;
          lane_s = eff_lane(req_op, req_addr[1:0]);
          rt_s   = req_rt_old;
          if ((req_op > OP_FETCH) || (ALIGN_CHECK && is_misaligned(req_op, req_addr[1:0]))) begin
            state_s      = ST_RESP;
            resp_valid_s = 1'b1;
            resp_err_s   = 1'b1;
          end else begin
            state_s      = ST_BUS;
            cnt_s        = '0;
            address_s    = {req_addr[31:2], 2'b00};
            read_s       = !is_store(req_op);
            write_s      = is_store(req_op);
            byteenable_s = is_store(req_op) ? store_be(req_op, eff_lane(req_op, req_addr[1:0]))
                                            : 4'b1111;
            writedata_s  = is_store(req_op) ? store_data(req_op, req_wdata) : 32'h0000_0000;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (!waitrequest) begin
          state_s      = ST_RESP;
          resp_valid_s = 1'b1;
          resp_rdata_s = read_r ? load_result(op_r, lane_r, readdata, rt_r) : 32'h0000_0000;
          read_s       = 1'b0;
          write_s      = 1'b0;
          byteenable_s = 4'b0000;
          writedata_s  = 32'h0000_0000;
        end else if (TMO_EN && (cnt_r == TMO_LAST)) begin
          state_s      = ST_RESP;
          resp_valid_s = 1'b1;
          resp_err_s   = 1'b1;
          read_s       = 1'b0;
          write_s      = 1'b0;
          byteenable_s = 4'b0000;
          writedata_s  = 32'h0000_0000;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        read_s  = 1'b0;
        write_s = 1'b0;
      end
    endcase
    req_ready_s = (state_s == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      op_r         <= 4'd0;
      lane_r       <= 2'd0;
      rt_r         <= 32'h0000_0000;
      cnt_r        <= '0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      address_r    <= 32'h0000_0000;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      writedata_r  <= 32'h0000_0000;
      byteenable_r <= 4'b0000;
    end else begin
      state_r      <= state_s;
      op_r         <= op_s;
      lane_r       <= lane_s;
      rt_r         <= rt_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_rdata_r <= resp_rdata_s;
      address_r    <= address_s;
      read_r       <= read_s;
      write_r      <= write_s;
      writedata_r  <= writedata_s;
      byteenable_r <= byteenable_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign address    = address_r;
  assign read       = read_r;
  assign write      = write_r;
  assign writedata  = writedata_r;
  assign byteenable = byteenable_r;

endmodule

// File: tb/tb_mips_cpu_lsu.sv
// Self-checking bench for mips_cpu_lsu (TIMEOUT_CYCLES=8, ALIGN_CHECK=1).
// Directed vector table, randomized transactions against a behavioural model,
// and hand-written sequences for reset mid-transfer and ignored requests.
module tb_mips_cpu_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_rt_old = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest = 1'b0;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata = 32'h0;

  always #5 clk = ~clk;

  mips_cpu_lsu #(.TIMEOUT_CYCLES(TMO), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt_old(req_rt_old),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rt;
    logic [31:0] m;
    int          nwait;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  // Reference model straight from the load/store rules, using shifts and masks.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rt,
                                 input logic [31:0] m, input int nwait);
    vec_t v;
    int n, sh;
    logic [31:0] bval, hval;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rt = rt; v.m = m; v.nwait = nwait;
    v.rdata = 32'h0; v.err = 1'b0; v.be = 4'hF; v.wd = 32'h0;
    n = int'(addr[1:0]);
    if (op > 4'd10 ||
        ((op == 4'd0 || op == 4'd7 || op == 4'd10) && n != 0) ||
        ((op == 4'd1 || op == 4'd2 || op == 4'd8) && (n % 2) == 1)) begin
      v.err = 1'b1; v.lat = 1;
      return v;
    end
    if (op == 4'd7) begin v.be = 4'hF; v.wd = wdata; end
    if (op == 4'd8) begin v.be = 4'(3 << (n & 2)); v.wd = {16'h0, wdata[15:0]} * 32'h0001_0001; end
    if (op == 4'd9) begin v.be = 4'(1 << n); v.wd = {24'h0, wdata[7:0]} * 32'h0101_0101; end
    if (nwait >= TMO) begin
      v.err = 1'b1; v.lat = TMO + 1;
      return v;
    end
    v.lat = 2 + nwait;
    bval = (m >> (8 * n)) & 32'hFF;
    hval = (m >> (8 * (n & 2))) & 32'hFFFF;
    case (op)
      4'd0, 4'd10: v.rdata = m;
      4'd1: v.rdata = (hval >= 32'h8000) ? (hval | 32'hFFFF_0000) : hval;
      4'd2: v.rdata = hval;
      4'd3: v.rdata = (bval >= 32'h80) ? (bval | 32'hFFFF_FF00) : bval;
      4'd4: v.rdata = bval;
      4'd5: begin sh = 8 * (3 - n); v.rdata = (m << sh) | (rt & ((32'd1 << sh) - 32'd1)); end
      4'd6: begin sh = 8 * n; v.rdata = (m >> sh) | (rt & ~(32'hFFFF_FFFF >> sh)); end
      default: v.rdata = 32'h0;
    endcase
    return v;
  endfunction

  // Drive one request from a negedge, play the slave, compare against v.
  task automatic run_and_check(input vec_t v, input string tag);
    logic [31:0] f_addr, f_wd, g_rdata;
    logic [3:0]  f_be;
    logic        f_wr, g_err, exp_wr;
    int buscyc, lat, unstable, both;
    buscyc = 0; lat = -1; unstable = 0; both = 0;
    f_addr = 32'h0; f_wd = 32'h0; f_be = 4'h0; f_wr = 1'b0; g_rdata = 32'h0; g_err = 1'b0;
    exp_wr = (v.op == 4'd7 || v.op == 4'd8 || v.op == 4'd9);
    check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    req_rt_old = v.rt; readdata = v.m; waitrequest = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (resp_valid) begin
        lat = c; g_rdata = resp_rdata; g_err = resp_err;
        break;
      end
      if (read || write) begin
        if (read && write) both++;
        if (buscyc == 0) begin
          f_addr = address; f_be = byteenable; f_wd = writedata; f_wr = write;
        end else if (address !== f_addr || byteenable !== f_be ||
                     writedata !== f_wd || write !== f_wr) begin
          unstable++;
        end
        buscyc++;
        waitrequest = (buscyc <= v.nwait);
      end
      @(negedge clk);
    end
    waitrequest = 1'b0;
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s resp_timeout: got no resp_valid within 40 cycles, expected one", tag);
      return;
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " err"}, {31'd0, g_err}, {31'd0, v.err});
    check({tag, " rdata"}, g_rdata, v.rdata);
    check({tag, " bus_cycles"}, buscyc, v.lat - 1);
    check({tag, " rw_exclusive"}, both, 0);
    check({tag, " stable"}, unstable, 0);
    if (buscyc > 0) begin
      check({tag, " address"}, f_addr, {v.addr[31:2], 2'b00});
      check({tag, " write"}, {31'd0, f_wr}, {31'd0, exp_wr});
      check({tag, " be"}, {28'd0, f_be}, {28'd0, v.be});
      if (exp_wr) check({tag, " writedata"}, f_wd, v.wd);
    end
    @(negedge clk);
    check({tag, " resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    check({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
  endtask

  vec_t tbl[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rt, input logic [31:0] m, input int nwait,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input logic [3:0] be, input logic [31:0] wd);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rt = rt; v.m = m; v.nwait = nwait;
    v.rdata = rdata; v.err = err; v.lat = lat; v.be = be; v.wd = wd;
    return v;
  endfunction

  initial begin
    int reads, writes_seen, extra, got_resp;
    vec_t v;

    // Directed vectors with hand-derived expectations.
    tbl.push_back(mk(4'd0,  32'h1000, 32'h0, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd3,  32'h1003, 32'h0, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd4,  32'h1003, 32'h0, 32'h0, 32'h80112233, 0, 32'h00000080, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd9,  32'h1002, 32'h000000AB, 32'h0, 32'h0, 0, 32'h0, 1'b0, 2, 4'b0100, 32'hABABABAB));
    tbl.push_back(mk(4'd5,  32'h1001, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'h3344CCDD, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd6,  32'h1001, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 32'hAA112233, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd0,  32'h1002, 32'h0, 32'h0, 32'h12345678, 0, 32'h0, 1'b1, 1, 4'hF, 32'h0));
    tbl.push_back(mk(4'd8,  32'h1001, 32'h1234, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 4'hF, 32'h0));
    tbl.push_back(mk(4'd7,  32'h2000, 32'h12345678, 32'h0, 32'h0, 5, 32'h0, 1'b0, 7, 4'hF, 32'h12345678));
    tbl.push_back(mk(4'd7,  32'h2004, 32'hCAFEF00D, 32'h0, 32'h0, 100, 32'h0, 1'b1, 9, 4'hF, 32'hCAFEF00D));
    tbl.push_back(mk(4'd11, 32'h1000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b1, 1, 4'hF, 32'h0));
    tbl.push_back(mk(4'd10, 32'h0000_0040, 32'h0, 32'h0, 32'h24080001, 1, 32'h24080001, 1'b0, 3, 4'hF, 32'h0));
    tbl.push_back(mk(4'd1,  32'h1002, 32'h0, 32'h0, 32'h80112233, 0, 32'hFFFF8011, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd2,  32'h1002, 32'h0, 32'h0, 32'h80112233, 0, 32'h00008011, 1'b0, 2, 4'hF, 32'h0));
    tbl.push_back(mk(4'd8,  32'h1002, 32'h0000BEEF, 32'h0, 32'h0, 0, 32'h0, 1'b0, 2, 4'b1100, 32'hBEEFBEEF));
    tbl.push_back(mk(4'd0,  32'h3000, 32'h0, 32'h0, 32'h55AA55AA, 12, 32'h0, 1'b1, 9, 4'hF, 32'h0));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst read",       {31'd0, read},       32'd0);
    check("rst write",      {31'd0, write},      32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst resp_err",   {31'd0, resp_err},   32'd0);
    check("rst resp_rdata", resp_rdata,          32'd0);
    check("rst address",    address,             32'd0);
    check("rst writedata",  writedata,           32'd0);
    check("rst byteenable", {28'd0, byteenable}, 32'd0);
    check("rst req_ready",  {31'd0, req_ready},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst req_ready", {31'd0, req_ready}, 32'd1);

    foreach (tbl[i]) run_and_check(tbl[i], $sformatf("vec%0d", i));

    // Randomized transactions against the model.
    for (int i = 0; i < 60; i++) begin
      v = model(4'($urandom_range(0, 12)), $urandom, $urandom, $urandom, $urandom,
                ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 3)));
      run_and_check(v, $sformatf("rnd%0d op%0d", i, v.op));
    end

    // Reset while the bus is stalled: transfer is abandoned silently.
    req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h3000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; waitrequest = 1'b1;
    check("rstmid read_high", {31'd0, read}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid read",       {31'd0, read},       32'd0);
    check("rstmid resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rstmid req_ready",  {31'd0, req_ready},  32'd0);
    rst = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    check("rstmid ready_after", {31'd0, req_ready}, 32'd1);
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid || read) extra++;
      @(negedge clk);
    end
    check("rstmid no_resp", extra, 0);

    // A request held during BUS/RESP is neither accepted nor queued.
    req_valid = 1'b1; req_op = 4'd7; req_addr = 32'h4000; req_wdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_op = 4'd0; req_addr = 32'h5000;
    reads = 0; writes_seen = 0; got_resp = 0;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid) begin
        got_resp = 1; req_valid = 1'b0;
        break;
      end
      if (read) reads++;
      if (write) begin
        writes_seen++;
        waitrequest = (writes_seen <= 2);
      end
      @(negedge clk);
    end
    waitrequest = 1'b0;
    req_valid = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (read || resp_valid) extra++;
    end
    check("ignore got_resp", got_resp, 1);
    check("ignore write_cycles", writes_seen, 3);
    check("ignore no_read", reads + extra, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test by 200000, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
